// File: rtl/knn_query_ctrl.sv
// KNN query sequencer: clears the top-K sorter, replays cached neighbours (warm start),
// streams every dataset address, waits for the sorter, then commits the new top-K to the cache.
module knn_query_ctrl #(
   parameter int unsigned K        = 10,
   parameter int unsigned N_POINTS = 1024,
   parameter int unsigned ADDR_W   = (N_POINTS > 1) ? $clog2(N_POINTS) : 1,
   parameter int unsigned IDX_W    = (K > 1) ? $clog2(K) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              query_valid,
   output logic              query_ready,
   input  logic              cache_invalidate,
   input  logic              dp_ready,
   output logic              dp_issue,
   output logic              dp_src,
   output logic [IDX_W-1:0]  cache_rd_idx,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              topk_clear,
   input  logic              topk_done,
   output logic              cache_load,
   output logic              query_done,
   output logic              warm_valid,
   output logic              busy
);

   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(K - 1);
   localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(N_POINTS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_WARM,
      S_STREAM,
      S_DRAIN,
      S_WB
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [IDX_W-1:0]  r_idx;
   logic [IDX_W-1:0]  w_idx_nxt;
   logic [ADDR_W-1:0] r_addr;
   logic [ADDR_W-1:0] w_addr_nxt;
   logic              r_warm_valid;
   logic              w_warm_nxt;

   logic r_query_ready, w_query_ready_nxt;
   logic r_dp_issue,    w_dp_issue_nxt;
   logic r_dp_src,      w_dp_src_nxt;
   logic r_topk_clear,  w_topk_clear_nxt;
   logic r_wb,          w_wb_nxt;
   logic r_busy,        w_busy_nxt;

   // Next state, counters and the registered Moore outputs decoded from the next state
   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_addr_nxt  = r_addr;
      w_warm_nxt  = r_warm_valid;

      if (cache_invalidate) begin
         w_warm_nxt = 1'b0;
      end

      case (r_state)
         S_IDLE: begin
            if (query_valid && r_query_ready) begin
               w_state_nxt = S_CLEAR;
            end
         end
         S_CLEAR: begin
            w_idx_nxt   = '0;
            w_addr_nxt  = '0;
            w_state_nxt = r_warm_valid ? S_WARM : S_STREAM;
         end
         S_WARM: begin
            if (dp_ready) begin
               if (r_idx == IDX_LAST) begin
                  w_idx_nxt   = '0;
                  w_state_nxt = S_STREAM;
               end else begin
                  w_idx_nxt = r_idx + IDX_W'(1);
               end
            end
         end
         S_STREAM: begin
            if (dp_ready) begin
               if (r_addr == ADDR_LAST) begin
                  w_addr_nxt  = '0;
                  w_state_nxt = S_DRAIN;
               end else begin
                  w_addr_nxt = r_addr + ADDR_W'(1);
               end
            end
         end
         S_DRAIN: begin
            if (topk_done) begin
               w_state_nxt = S_WB;
            end
         end
         S_WB: begin
            // The capture of fresh results outranks a same-cycle invalidate
            w_warm_nxt  = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase

      w_query_ready_nxt = (w_state_nxt == S_IDLE);
      w_dp_issue_nxt    = (w_state_nxt == S_WARM) || (w_state_nxt == S_STREAM);
      w_dp_src_nxt      = (w_state_nxt == S_STREAM);
      w_topk_clear_nxt  = (w_state_nxt == S_CLEAR);
      w_wb_nxt          = (w_state_nxt == S_WB);
      w_busy_nxt        = (w_state_nxt != S_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_idx         <= '0;
         r_addr        <= '0;
         r_warm_valid  <= 1'b0;
         r_query_ready <= 1'b1;
         r_dp_issue    <= 1'b0;
         r_dp_src      <= 1'b0;
         r_topk_clear  <= 1'b0;
         r_wb          <= 1'b0;
         r_busy        <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_idx         <= w_idx_nxt;
         r_addr        <= w_addr_nxt;
         r_warm_valid  <= w_warm_nxt;
         r_query_ready <= w_query_ready_nxt;
         r_dp_issue    <= w_dp_issue_nxt;
         r_dp_src      <= w_dp_src_nxt;
         r_topk_clear  <= w_topk_clear_nxt;
         r_wb          <= w_wb_nxt;
         r_busy        <= w_busy_nxt;
      end
   end

   assign query_ready  = r_query_ready;
   assign dp_issue     = r_dp_issue;
   assign dp_src       = r_dp_src;
   assign cache_rd_idx = r_idx;
   assign mem_addr     = r_addr;
   assign topk_clear   = r_topk_clear;
   assign cache_load   = r_wb;
   assign query_done   = r_wb;
   assign warm_valid   = r_warm_valid;
   assign busy         = r_busy;

endmodule

// File: tb/tb_knn_query_ctrl.sv
// Scoreboard bench for knn_query_ctrl: expected issue sequence queued at query accept, checked per cycle.
module tb_knn_query_ctrl;

   localparam int unsigned K        = 10;
   localparam int unsigned N_POINTS = 8;
   localparam int unsigned ADDR_W   = 3;
   localparam int unsigned IDX_W    = 4;

   logic              clk;
   logic              rst;
   logic              query_valid;
   logic              query_ready;
   logic              cache_invalidate;
   logic              dp_ready;
   logic              dp_issue;
   logic              dp_src;
   logic [IDX_W-1:0]  cache_rd_idx;
   logic [ADDR_W-1:0] mem_addr;
   logic              topk_clear;
   logic              topk_done;
   logic              cache_load;
   logic              query_done;
   logic              warm_valid;
   logic              busy;

   typedef struct packed {
      logic        src;
      logic [31:0] v;
   } iss_t;

   iss_t q[$];
   int   n_cmp;
   int   n_err;
   logic exp_wv;

   knn_query_ctrl #(
      .K        (K),
      .N_POINTS (N_POINTS),
      .ADDR_W   (ADDR_W),
      .IDX_W    (IDX_W)
   ) u_dut (
      .clk              (clk),
      .rst              (rst),
      .query_valid      (query_valid),
      .query_ready      (query_ready),
      .cache_invalidate (cache_invalidate),
      .dp_ready         (dp_ready),
      .dp_issue         (dp_issue),
      .dp_src           (dp_src),
      .cache_rd_idx     (cache_rd_idx),
      .mem_addr         (mem_addr),
      .topk_clear       (topk_clear),
      .topk_done        (topk_done),
      .cache_load       (cache_load),
      .query_done       (query_done),
      .warm_valid       (warm_valid),
      .busy             (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // Runs one query starting and ending at a negedge with the DUT idle
   task automatic do_query(input bit bp, input int dly, input bit hold,
                           input bit stray, input bit inv_clr, input bit inv_wb);
      int   cyc;
      int   drain;
      int   ph;
      int   issue_cyc;
      int   accepts;
      int   kw;
      bit   done_seen;
      bit   wb_exp;
      bit   stray_done;
      iss_t e;
      logic pat [4];
      pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
      drain = 0; ph = 0; issue_cyc = 0; accepts = 0;
      done_seen = 1'b0; wb_exp = 1'b0; stray_done = 1'b0;
      kw = exp_wv ? int'(K) : 0;

      chk("idle_ready", 32'(query_ready), 1);
      chk("idle_busy", 32'(busy), 0);
      chk("idle_warm", 32'(warm_valid), 32'(exp_wv));
      for (int i = 0; i < kw; i++) q.push_back('{src: 1'b0, v: 32'(i)});
      for (int i = 0; i < int'(N_POINTS); i++) q.push_back('{src: 1'b1, v: 32'(i)});
      query_valid = 1'b1;
      dp_ready    = 1'b1;

      @(negedge clk);
      if (!hold) query_valid = 1'b0;
      chk("clr_pulse", 32'(topk_clear), 1);
      chk("clr_ready", 32'(query_ready), 0);
      chk("clr_issue", 32'(dp_issue), 0);
      chk("clr_busy", 32'(busy), 1);
      chk("clr_idx", 32'(cache_rd_idx), 0);
      chk("clr_addr", 32'(mem_addr), 0);
      if (inv_clr) begin
         cache_invalidate = 1'b1;
         exp_wv = 1'b0;
      end
      cyc = 1;

      while (!done_seen && cyc < 500) begin
         @(negedge clk);
         cyc++;
         cache_invalidate = 1'b0;
         topk_done        = 1'b0;
         chk("warm", 32'(warm_valid), 32'(exp_wv));
         chk("ready", 32'(query_ready), 0);
         chk("busy", 32'(busy), 1);
         chk("clr_once", 32'(topk_clear), 0);
         chk("issue", 32'(dp_issue), 32'(q.size() != 0));
         if (q.size() != 0) begin
            e = q[0];
            issue_cyc++;
            chk("src", 32'(dp_src), 32'(e.src));
            if (e.src) chk("addr", 32'(mem_addr), e.v);
            else       chk("idx", 32'(cache_rd_idx), e.v);
            chk("load_busy", 32'(cache_load), 0);
            dp_ready = bp ? pat[ph % 4] : 1'b1;
            ph++;
            if (stray && !stray_done && e.src) begin
               topk_done  = 1'b1;
               stray_done = 1'b1;
            end
            if (dp_ready) begin
               void'(q.pop_front());
               accepts++;
            end
         end else if (wb_exp) begin
            chk("load", 32'(cache_load), 1);
            chk("qdone", 32'(query_done), 1);
            chk("drain_len", 32'(drain), 32'(dly));
            if (inv_wb) cache_invalidate = 1'b1;
            exp_wv    = 1'b1;
            done_seen = 1'b1;
         end else begin
            drain++;
            chk("drain_load", 32'(cache_load), 0);
            chk("drain_qdone", 32'(query_done), 0);
            if (drain == dly) begin
               topk_done = 1'b1;
               wb_exp    = 1'b1;
            end
         end
      end
      chk("timeout", 32'(done_seen), 1);
      chk("accepts", 32'(accepts), 32'(kw + int'(N_POINTS)));
      if (!bp) begin
         chk("issue_cycles", 32'(issue_cyc), 32'(kw + int'(N_POINTS)));
         chk("latency", 32'(cyc), 32'(1 + kw + int'(N_POINTS) + dly + 1));
      end

      @(negedge clk);
      cache_invalidate = 1'b0;
      topk_done        = 1'b0;
      chk("end_ready", 32'(query_ready), 1);
      chk("end_busy", 32'(busy), 0);
      chk("end_load", 32'(cache_load), 0);
      chk("end_issue", 32'(dp_issue), 0);
      chk("end_warm", 32'(warm_valid), 32'(exp_wv));
   endtask

   initial begin
      bit found;
      n_cmp = 0;
      n_err = 0;
      exp_wv = 1'b0;
      rst = 1'b1;
      query_valid = 1'b0;
      cache_invalidate = 1'b0;
      dp_ready = 1'b0;
      topk_done = 1'b0;

      repeat (2) @(negedge clk);
      chk("rst_ready", 32'(query_ready), 1);
      chk("rst_issue", 32'(dp_issue), 0);
      chk("rst_clear", 32'(topk_clear), 0);
      chk("rst_load", 32'(cache_load), 0);
      chk("rst_qdone", 32'(query_done), 0);
      chk("rst_warm", 32'(warm_valid), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_idx", 32'(cache_rd_idx), 0);
      chk("rst_addr", 32'(mem_addr), 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      do_query(1'b0, 3, 1'b0, 1'b0, 1'b0, 1'b0);   // cold
      do_query(1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b0);   // warm
      do_query(1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b0);   // backpressure
      do_query(1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b1);   // invalidate in WB loses

      cache_invalidate = 1'b1;
      @(negedge clk);
      cache_invalidate = 1'b0;
      exp_wv = 1'b0;
      chk("idle_inv", 32'(warm_valid), 0);
      do_query(1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b0);   // no WARM phase expected
      do_query(1'b0, 1, 1'b0, 1'b0, 1'b1, 1'b0);   // invalidate in CLEAR: old value branches

      do_query(1'b0, 2, 1'b1, 1'b1, 1'b0, 1'b0);   // query_valid held, stray topk_done
      do_query(1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0);

      // Reset in the middle of STREAM
      chk("pre_rst_warm", 32'(warm_valid), 1);
      query_valid = 1'b1;
      dp_ready = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         @(negedge clk);
         query_valid = 1'b0;
         if (dp_issue && dp_src && mem_addr == ADDR_W'(5)) found = 1'b1;
      end
      chk("reach_addr5", 32'(found), 1);
      #2 rst = 1'b1;
      #1;
      chk("arst_ready", 32'(query_ready), 1);
      chk("arst_issue", 32'(dp_issue), 0);
      chk("arst_src", 32'(dp_src), 0);
      chk("arst_addr", 32'(mem_addr), 0);
      chk("arst_busy", 32'(busy), 0);
      chk("arst_warm", 32'(warm_valid), 0);
      chk("arst_load", 32'(cache_load), 0);
      chk("arst_qdone", 32'(query_done), 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_hold_load", 32'(cache_load), 0);
      end
      rst = 1'b0;
      q.delete();
      exp_wv = 1'b0;
      @(negedge clk);
      chk("post_rst_load", 32'(cache_load), 0);
      do_query(1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0);   // cold after reset

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/knn_query_ctrl.md
Name: knn_query_ctrl

Overview:
- Sequencer for one KNN query pass over the distance datapath.
- On an accepted query it:
  - pulses a clear to the top-K sorter;
  - replays the K previous-query neighbours from the previous-KNN cache into the parallel distance compare (warm start), if that cache holds valid results;
  - streams every dataset point address;
  - waits for the sorter's completion, then commands the cache to capture the new top-K.
- Sits between the host/control logic and the cache, dataset memory, compare and top-K blocks.

Parameters:
- K, 10, neighbours per query and cache depth.
- N_POINTS, 1024, dataset points streamed per query (>= 1).
- ADDR_W, $clog2(N_POINTS), dataset address width.
- IDX_W, $clog2(K), cache index width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- query_valid  in  1  host requests a new query.
- query_ready  out  1  controller idle; accepts a query this cycle.
- cache_invalidate  in  1  discard warm-start results (e.g. dataset reload).
- dp_ready  in  1  distance compare accepts an issue this cycle.
- dp_issue  out  1  issue valid to distance compare.
- dp_src  out  1  0 = cache entry, 1 = dataset point.
- cache_rd_idx  out  IDX_W  cache entry index being issued.
- mem_addr  out  ADDR_W  dataset point address being issued.
- topk_clear  out  1  one-cycle clear to top-K sorter.
- topk_done  in  1  sorter finished final insertion.
- cache_load  out  1  one-cycle capture strobe to previous-KNN cache.
- query_done  out  1  one-cycle completion pulse to host.
- warm_valid  out  1  cache currently holds usable results.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE; warm_valid = 0; all counters = 0.
  - All pulses/issues 0, so query_ready = 1.
- States: IDLE, CLEAR, WARM, STREAM, DRAIN, WB.
- IDLE:
  - query_ready = 1.
  - Accept = query_valid & query_ready. On accept go to CLEAR.
- CLEAR:
  - topk_clear = 1 for exactly this cycle.
  - Next state is WARM if warm_valid, else STREAM. warm_valid is sampled in this cycle.
  - cache_rd_idx and mem_addr are set to 0.
- WARM:
  - dp_issue = 1, dp_src = 0.
  - Handshake: cache_rd_idx advances only on dp_issue & dp_ready.
  - The accept with cache_rd_idx == K-1 goes to STREAM and wraps cache_rd_idx to 0.
  - Exactly K issues are accepted.
- STREAM:
  - dp_issue = 1, dp_src = 1.
  - mem_addr advances on accept.
  - The accept at N_POINTS-1 goes to DRAIN with mem_addr = 0.
  - Exactly N_POINTS issues are accepted, in ascending address order.
- DRAIN:
  - dp_issue = 0.
  - Waits for topk_done, then goes to WB.
  - topk_done is ignored in every other state.
- WB:
  - cache_load = 1 and query_done = 1 in the same single cycle.
  - Sets warm_valid = 1, then returns to IDLE.
- Output timing:
  - All outputs are functions of registered state/counters only (Moore).
  - No combinational path from dp_ready, query_valid or topk_done to any output.
- Stalls: while dp_ready = 0, dp_issue stays 1 and cache_rd_idx, mem_addr and dp_src stay stable.
- cache_invalidate:
  - Clears warm_valid on the next edge in any state.
  - An in-progress WARM still completes all K issues.
  - If asserted in the WB cycle, WB's set wins and warm_valid = 1.
  - If asserted in the CLEAR cycle, the old warm_valid value is used for the branch.
- query_valid while busy: not accepted (query_ready = 0); no queuing.
- Reset mid-query:
  - Immediately returns to IDLE with warm_valid = 0.
  - No cache_load is emitted.
- Throughput: with dp_ready held at 1, one query takes 1 + 1 + K + N_POINTS + (DRAIN cycles) + 1 cycles from accept to return to IDLE.
- Counter widths: cache_rd_idx never exceeds K-1 and mem_addr never exceeds N_POINTS-1. Wrap to 0 is mandatory, including when N_POINTS or K is a power of two.

Test Plan:
- Cold query:
  - Stimulus: reset, query_valid pulse, dp_ready = 1, N_POINTS = 8, topk_done 3 cycles after DRAIN entry.
  - Required: topk_clear 1 cycle; 0 WARM issues; mem_addr 0..7 on consecutive cycles; cache_load and query_done together; warm_valid becomes 1.
- Warm query:
  - Stimulus: a second query after the cold query.
  - Required: K = 10 issues with dp_src = 0, cache_rd_idx 0..9, then 8 dataset issues; total dp_issue cycles = 18.
- Backpressure:
  - Stimulus: dp_ready toggles 1,0,0,1 repeatedly.
  - Required: issue count still exactly K + N_POINTS; indices never skip or repeat; outputs stable while stalled.
- Invalidate:
  - Stimulus: cache_invalidate in the WB cycle, then a separate pulse in IDLE, then a query.
  - Required: warm_valid = 1 after the WB cycle, 0 after the IDLE pulse; the next query has no WARM phase.
- Reset mid-STREAM:
  - Stimulus: assert rst at mem_addr = 5.
  - Required: all outputs 0 and query_ready = 1 asynchronously; warm_valid = 0; no cache_load emitted.
- Busy rejection:
  - Stimulus: hold query_valid = 1 throughout a query.
  - Required: exactly one accept per IDLE visit; query_ready = 0 in all other states; topk_done pulsed in STREAM is ignored.
